regfile_wb_arbiter: RTL and testbench

//  Shares the single register-file write port between two writeback requesters:
//  ALU result (req 0) and load/memory result (req 1).

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter2.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 94 +++++++++
 tb/tb_regfile_wb_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
// Requester indices double as the bit positions in the arbiter's one-hot grant.
package regfile_pkg;
    localparam int XLEN    = 32;
    localparam int REG_AW  = 5;
    localparam int REQ_ALU = 0;
    localparam int REQ_MEM = 1;

    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [XLEN-1:0]   data;
    } wb_req_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter with a one-hot grant.
// The pointer selects the winner only when both requesters contend.
module rr_arbiter2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic rr_ptr_q, rr_ptr_d;

    always_comb begin
        gnt_o = req_i;
        if (&req_i) gnt_o = rr_ptr_q ? 2'b10 : 2'b01;
    end

    // After a grant, favour whoever lost; with no grant the pointer holds.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_o[REQ_ALU])      rr_ptr_d = 1'b1;
        else if (gnt_o[REQ_MEM]) rr_ptr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= 1'b0;
        else     rr_ptr_q <= rr_ptr_d;
    end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Define WB_FORWARD_EN to bypass the in-flight write onto the read ports.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_addr,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_ready,
    input  logic              mem_valid,
    input  logic [REG_AW-1:0] mem_addr,
    input  logic [XLEN-1:0]   mem_data,
    output logic              mem_ready,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    input  logic [REG_AW-1:0] readReg1,
    input  logic [REG_AW-1:0] readReg2,
    input  logic [XLEN-1:0]   read1,
    input  logic [XLEN-1:0]   read2,
    output logic [XLEN-1:0]   fwd_read1,
    output logic [XLEN-1:0]   fwd_read2
);
    logic       alu_sink, mem_sink;
    logic [1:0] arb_req, gnt;
    wb_req_t    alu_req, mem_req, win_req;

    logic              rf_we_q, rf_we_d;
    logic [REG_AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0]   rf_wdata_q, rf_wdata_d;

    // x0 writes are acknowledged immediately and never reach the arbiter.
    assign alu_sink = alu_valid && (alu_addr == '0);
    assign mem_sink = mem_valid && (mem_addr == '0);

    assign arb_req[REQ_ALU] = !rst && alu_valid && (alu_addr != '0);
    assign arb_req[REQ_MEM] = !rst && mem_valid && (mem_addr != '0);

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i (arb_req),
        .gnt_o (gnt)
    );

    assign alu_ready = !rst && (alu_sink || gnt[REQ_ALU]);
    assign mem_ready = !rst && (mem_sink || gnt[REQ_MEM]);

    assign alu_req = '{addr: alu_addr, data: alu_data};
    assign mem_req = '{addr: mem_addr, data: mem_data};
    assign win_req = gnt[REQ_MEM] ? mem_req : alu_req;

    always_comb begin
        rf_we_d    = |gnt;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (|gnt) begin
            rf_waddr_d = win_req.addr;
            rf_wdata_d = win_req.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;

`ifdef WB_FORWARD_EN
    // The regfile only holds the new value from the cycle after rf_we.
    assign fwd_read1 = (rf_we_q && (rf_waddr_q == readReg1) && (readReg1 != '0)) ? rf_wdata_q : read1;
    assign fwd_read2 = (rf_we_q && (rf_waddr_q == readReg2) && (readReg2 != '0)) ? rf_wdata_q : read2;
`else
    logic unused_rd_addr;
    assign unused_rd_addr = ^{readReg1, readReg2};
    assign fwd_read1      = read1;
    assign fwd_read2      = read2;
`endif
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus a
// randomized run against a behavioural model with an attached register file.
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, mem_valid, alu_ready, mem_ready, rf_we;
    logic [4:0]  alu_addr, mem_addr, rf_waddr, readReg1, readReg2;
    logic [31:0] alu_data, mem_data, rf_wdata, read1, read2, fwd_read1, fwd_read2;

    int errors = 0;
    int checks = 0;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    regfile_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .readReg1(readReg1), .readReg2(readReg2), .read1(read1), .read2(read2),
        .fwd_read1(fwd_read1), .fwd_read2(fwd_read2)
    );

    always #5 clk = ~clk;

    // Register file driven by the DUT's write pins.
    logic [31:0] rf_mem [32];
    always @(posedge clk) if (rf_we && rf_waddr != 5'd0) rf_mem[rf_waddr] <= rf_wdata;
    assign read1 = rf_mem[readReg1];
    assign read2 = rf_mem[readReg2];

    // Behavioural model state.
    int          m_ptr;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] exp_rf [32];

    task automatic model_eval(output logic ar, output logic mr, output int win);
        bit aw, mw;
        aw  = alu_valid && alu_addr != 5'd0;
        mw  = mem_valid && mem_addr != 5'd0;
        win = -1;
        if (aw && mw) win = m_ptr;
        else if (aw)  win = 0;
        else if (mw)  win = 1;
        ar = alu_valid && (alu_addr == 5'd0 || win == 0);
        mr = mem_valid && (mem_addr == 5'd0 || win == 1);
    endtask

    task automatic model_adv(input int win);
        if (m_we) exp_rf[m_waddr] = m_wdata;
        m_we = (win >= 0);
        if (win == 0) begin m_waddr = alu_addr; m_wdata = alu_data; m_ptr = 1; end
        if (win == 1) begin m_waddr = mem_addr; m_wdata = mem_data; m_ptr = 0; end
    endtask

    task automatic do_reset();
        alu_valid = 0; mem_valid = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0;
        m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
    endtask

    task automatic test_reset();
        alu_valid = 1; alu_addr = 5; alu_data = 32'hA5A5_0001;
        mem_valid = 1; mem_addr = 6; mem_data = 32'h5A5A_0002;
        @(posedge clk); #1;
        checks += 5;
        if (rf_we !== 1'b0)     begin errors++; $display("FAIL reset_we got=%b exp=0", rf_we); end
        if (rf_waddr !== 5'd0)  begin errors++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
        if (rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
        if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_alu_ready got=%b exp=0", alu_ready); end
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL reset_mem_ready got=%b exp=0", mem_ready); end
        rst = 0; #1;
        checks += 2;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL release_alu_first got=%b exp=1", alu_ready); end
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL release_mem_wait got=%b exp=0", mem_ready); end
        @(posedge clk); #1;
        alu_valid = 0;
        checks += 2;
        if (rf_we !== 1'b1)    begin errors++; $display("FAIL first_we got=%b exp=1", rf_we); end
        if (rf_waddr !== 5'd5) begin errors++; $display("FAIL first_waddr got=%0d exp=5", rf_waddr); end
        rst = 1; #1;
        checks += 3;
        if (rf_we !== 1'b0)     begin errors++; $display("FAIL async_clr_we got=%b exp=0", rf_we); end
        if (rf_waddr !== 5'd0)  begin errors++; $display("FAIL async_clr_waddr got=%0d exp=0", rf_waddr); end
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL rst_mem_ready got=%b exp=0", mem_ready); end
        @(posedge clk); #1;
        rst = 0; alu_valid = 1; alu_addr = 5; alu_data = 32'hA5A5_0003; #1;
        checks += 2;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL rerelease_alu got=%b exp=1", alu_ready); end
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL rerelease_mem got=%b exp=0", mem_ready); end
        @(posedge clk); #1;
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_single_write();
        do_reset();
        readReg1 = 5;
        alu_valid = 1; alu_addr = 5; alu_data = 32'hDEADBEEF; #1;
        checks++;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", alu_ready); end
        @(posedge clk); #1;
        alu_valid = 0; #1;
        checks += 3;
        if (rf_we !== 1'b1)            begin errors++; $display("FAIL single_we got=%b exp=1", rf_we); end
        if (rf_waddr !== 5'd5)         begin errors++; $display("FAIL single_waddr got=%0d exp=5", rf_waddr); end
        if (rf_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_wdata got=%h exp=deadbeef", rf_wdata); end
        @(posedge clk); #1;
        checks += 3;
        if (rf_we !== 1'b0)             begin errors++; $display("FAIL idle_we got=%b exp=0", rf_we); end
        if (rf_waddr !== 5'd5)          begin errors++; $display("FAIL idle_hold_waddr got=%0d exp=5", rf_waddr); end
        if (fwd_read1 !== 32'hDEADBEEF) begin errors++; $display("FAIL single_read got=%h exp=deadbeef", fwd_read1); end
    endtask

    task automatic test_alternate();
        logic [31:0] last_data;
        int          last_win;
        do_reset();
        alu_valid = 1; alu_addr = 3; alu_data = $urandom;
        mem_valid = 1; mem_addr = 4; mem_data = $urandom;
        last_win = -1; last_data = 0;
        for (int k = 0; k < 6; k++) begin
            #1;
            checks += 2;
            if (alu_ready !== (k % 2 == 0)) begin errors++; $display("FAIL alt_alu_ready k=%0d got=%b", k, alu_ready); end
            if (mem_ready !== (k % 2 == 1)) begin errors++; $display("FAIL alt_mem_ready k=%0d got=%b", k, mem_ready); end
            if (last_win >= 0) begin
                checks += 3;
                if (rf_we !== 1'b1) begin errors++; $display("FAIL alt_we k=%0d got=%b exp=1", k, rf_we); end
                if (rf_waddr !== (last_win == 0 ? 5'd3 : 5'd4))
                    begin errors++; $display("FAIL alt_waddr k=%0d got=%0d", k, rf_waddr); end
                if (rf_wdata !== last_data) begin errors++; $display("FAIL alt_wdata k=%0d got=%h exp=%h", k, rf_wdata, last_data); end
            end
            last_win  = k % 2;
            last_data = (k % 2 == 0) ? alu_data : mem_data;
            @(posedge clk); #1;
            if (k % 2 == 0) alu_data = $urandom; else mem_data = $urandom;
        end
        alu_valid = 0; mem_valid = 0;
    endtask

    task automatic test_x0_sink();
        do_reset();
        alu_valid = 1; alu_addr = 0; alu_data = 32'h1111;
        mem_valid = 1; mem_addr = 0; mem_data = 32'h2222; #1;
        checks += 2;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_alu_ready got=%b exp=1", alu_ready); end
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL x0_mem_ready got=%b exp=1", mem_ready); end
        @(posedge clk); #1;
        mem_addr = 8; mem_data = 32'h8888; #1;
        checks += 3;
        if (rf_we !== 1'b0)     begin errors++; $display("FAIL x0_we got=%b exp=0", rf_we); end
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL x0_mix_alu got=%b exp=1", alu_ready); end
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL x0_mix_mem got=%b exp=1", mem_ready); end
        @(posedge clk); #1;
        alu_valid = 0; mem_valid = 0;
        checks += 2;
        if (rf_we !== 1'b1)    begin errors++; $display("FAIL x0_mix_we got=%b exp=1", rf_we); end
        if (rf_waddr !== 5'd8) begin errors++; $display("FAIL x0_mix_waddr got=%0d exp=8", rf_waddr); end
    endtask

    task automatic test_same_dest();
        do_reset();
        readReg1 = 7;
        alu_valid = 1; alu_addr = 7; alu_data = 1;
        mem_valid = 1; mem_addr = 7; mem_data = 2; #1;
        checks += 2;
        if (alu_ready !== 1'b1) begin errors++; $display("FAIL same_alu_first got=%b exp=1", alu_ready); end
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL same_mem_wait got=%b exp=0", mem_ready); end
        @(posedge clk); #1;
        alu_valid = 0; #1;
        checks += 2;
        if (mem_ready !== 1'b1)   begin errors++; $display("FAIL same_mem_second got=%b exp=1", mem_ready); end
        if (rf_wdata !== 32'd1)   begin errors++; $display("FAIL same_w1 got=%h exp=1", rf_wdata); end
        @(posedge clk); #1;
        mem_valid = 0;
        checks++;
        if (rf_wdata !== 32'd2) begin errors++; $display("FAIL same_w2 got=%h exp=2", rf_wdata); end
        @(posedge clk); #1;
        checks++;
        if (fwd_read1 !== 32'd2) begin errors++; $display("FAIL same_final got=%h exp=2", fwd_read1); end
    endtask

    task automatic test_forward();
        do_reset();
        readReg1 = 0; readReg2 = 0;
        alu_valid = 1; alu_addr = 9; alu_data = 32'h11;
        @(posedge clk); #1;
        alu_valid = 0;
        @(posedge clk); #1;
        alu_valid = 1; alu_data = 32'h55;
        @(posedge clk); #1;
        alu_valid = 0; readReg1 = 9; #1;
        checks += 2;
        if (fwd_read1 !== (FWD ? 32'h55 : 32'h11))
            begin errors++; $display("FAIL fwd_inflight got=%h exp=%h", fwd_read1, FWD ? 32'h55 : 32'h11); end
        if (fwd_read2 !== read2) begin errors++; $display("FAIL fwd_passthru2 got=%h exp=%h", fwd_read2, read2); end
        @(posedge clk); #1;
        checks++;
        if (fwd_read1 !== 32'h55) begin errors++; $display("FAIL fwd_committed got=%h exp=55", fwd_read1); end
    endtask

    task automatic test_random();
        logic ear, emr, acc_a, acc_m;
        int   win;
        logic [31:0] exp_fwd;
        do_reset();
        exp_rf[0] = 0;
        for (int a = 1; a < 8; a++) begin
            alu_valid = 1; alu_addr = 5'(a); alu_data = $urandom; #1;
            model_eval(ear, emr, win); model_adv(win);
            @(posedge clk); #1;
        end
        alu_valid = 0;
        for (int i = 0; i < 2; i++) begin #1; model_eval(ear, emr, win); model_adv(win); @(posedge clk); #1; end
        acc_a = 1; acc_m = 1;
        for (int c = 0; c < 400; c++) begin
            if (acc_a || !alu_valid) begin
                alu_valid = ($urandom % 4) != 0; alu_addr = 5'($urandom % 8); alu_data = $urandom;
            end
            if (acc_m || !mem_valid) begin
                mem_valid = ($urandom % 4) != 0; mem_addr = 5'($urandom % 8); mem_data = $urandom;
            end
            readReg1 = 5'($urandom % 8); #1;
            model_eval(ear, emr, win);
            exp_fwd = (FWD && m_we && m_waddr == readReg1 && readReg1 != 0) ? m_wdata : exp_rf[readReg1];
            checks += 6;
            if (alu_ready !== ear)     begin errors++; $display("FAIL rnd_alu_ready c=%0d got=%b exp=%b", c, alu_ready, ear); end
            if (mem_ready !== emr)     begin errors++; $display("FAIL rnd_mem_ready c=%0d got=%b exp=%b", c, mem_ready, emr); end
            if (rf_we !== m_we)        begin errors++; $display("FAIL rnd_we c=%0d got=%b exp=%b", c, rf_we, m_we); end
            if (rf_waddr !== m_waddr)  begin errors++; $display("FAIL rnd_waddr c=%0d got=%0d exp=%0d", c, rf_waddr, m_waddr); end
            if (rf_wdata !== m_wdata)  begin errors++; $display("FAIL rnd_wdata c=%0d got=%h exp=%h", c, rf_wdata, m_wdata); end
            if (fwd_read1 !== exp_fwd) begin errors++; $display("FAIL rnd_fwd c=%0d got=%h exp=%h", c, fwd_read1, exp_fwd); end
            acc_a = alu_valid && alu_ready;
            acc_m = mem_valid && mem_ready;
            model_adv(win);
            @(posedge clk); #1;
        end
        alu_valid = 0; mem_valid = 0;
        for (int i = 0; i < 2; i++) begin #1; model_eval(ear, emr, win); model_adv(win); @(posedge clk); #1; end
        for (int a = 1; a < 8; a++) begin
            checks++;
            if (rf_mem[a] !== exp_rf[a]) begin errors++; $display("FAIL rnd_final x%0d got=%h exp=%h", a, rf_mem[a], exp_rf[a]); end
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rst = 1; alu_valid = 0; mem_valid = 0;
        alu_addr = 0; alu_data = 0; mem_addr = 0; mem_data = 0;
        readReg1 = 0; readReg2 = 0;
        m_ptr = 0; m_we = 0; m_waddr = 0; m_wdata = 0;
        test_reset();
        test_single_write();
        test_alternate();
        test_x0_sink();
        test_same_dest();
        test_forward();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
